music_sequencer: RTL

- Sequences note playback for the music player by stepping through a score ROM, one note per beat.
- The beat is the slow divided clock from the crystal clock divider, fed in as a level signal.
- Emits a tone-divider value to the tone generator, which drives the speaker.
- Handles play/pause/resume/stop commands, song selection and optional looping; sits between the clock divider, the button logic and the tone generator.

---
 rtl/music_pkg.sv | 59 +++++
 rtl/music_score_rom.sv | 56 +++++
 rtl/music_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
// Module   : music_pkg
// Brief    : Shared note codes, sequencer state encoding and note-to-divider
//            conversion for the music player.
// Revision : 1.0 - initial release
// ============================================================================
package music_pkg;

    localparam int c_song_len_default = 64;

    localparam logic [3:0] c_note_rest = 4'd0;
    localparam logic [3:0] c_note_c4   = 4'd1;
    localparam logic [3:0] c_note_d4   = 4'd2;
    localparam logic [3:0] c_note_e4   = 4'd3;
    localparam logic [3:0] c_note_f4   = 4'd4;
    localparam logic [3:0] c_note_g4   = 4'd5;
    localparam logic [3:0] c_note_a4   = 4'd6;
    localparam logic [3:0] c_note_b4   = 4'd7;
    localparam logic [3:0] c_note_c5   = 4'd8;
    localparam logic [3:0] c_note_d5   = 4'd9;
    localparam logic [3:0] c_note_e5   = 4'd10;
    localparam logic [3:0] c_note_f5   = 4'd11;
    localparam logic [3:0] c_note_g5   = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Frequencies held in centi-Hz so the rounded divide stays in integers.
    function automatic logic [63:0] note_to_div(input logic [3:0] code,
                                                input logic [63:0] clk_freq);
        logic [63:0] f_chz;
        case (code)
            c_note_c4: f_chz = 64'd26163;
            c_note_d4: f_chz = 64'd29366;
            c_note_e4: f_chz = 64'd32963;
            c_note_f4: f_chz = 64'd34923;
            c_note_g4: f_chz = 64'd39200;
            c_note_a4: f_chz = 64'd44000;
            c_note_b4: f_chz = 64'd49388;
            c_note_c5: f_chz = 64'd52325;
            c_note_d5: f_chz = 64'd58733;
            c_note_e5: f_chz = 64'd65926;
            c_note_f5: f_chz = 64'd69846;
            c_note_g5: f_chz = 64'd78399;
            default:   f_chz = 64'd0;
        endcase
        if (f_chz == 64'd0) begin
            return 64'd0;
        end
        return (clk_freq * 64'd100 + f_chz) / (64'd2 * f_chz);
    endfunction

endpackage
`default_nettype wire

// File: rtl/music_score_rom.sv
`default_nettype none
// ============================================================================
// Module   : music_score_rom
// Brief    : Combinational score ROM; each song is a 16-note phrase repeated
//            across the song length.
// Revision : 1.0 - initial release
// ============================================================================
module music_score_rom
    import music_pkg::*;
(
    input  logic       sel,
    input  logic [3:0] idx,
    output logic [3:0] note_code
);

    always_comb begin
        note_code = c_note_rest;
        case ({sel, idx})
            5'h00: note_code = c_note_a4;
            5'h01: note_code = c_note_c5;
            5'h02: note_code = c_note_e5;
            5'h03: note_code = c_note_c5;
            5'h04: note_code = c_note_a4;
            5'h05: note_code = c_note_g4;
            5'h06: note_code = c_note_rest;
            5'h07: note_code = c_note_a4;
            5'h08: note_code = c_note_c5;
            5'h09: note_code = c_note_e5;
            5'h0A: note_code = c_note_g5;
            5'h0B: note_code = c_note_e5;
            5'h0C: note_code = c_note_c5;
            5'h0D: note_code = c_note_a4;
            5'h0E: note_code = c_note_g4;
            5'h0F: note_code = 4'd15;
            5'h10: note_code = c_note_c4;
            5'h11: note_code = c_note_e4;
            5'h12: note_code = c_note_g4;
            5'h13: note_code = c_note_c5;
            5'h14: note_code = c_note_g4;
            5'h15: note_code = c_note_e4;
            5'h16: note_code = c_note_c4;
            5'h17: note_code = c_note_rest;
            5'h18: note_code = c_note_d4;
            5'h19: note_code = c_note_f4;
            5'h1A: note_code = c_note_a4;
            5'h1B: note_code = c_note_d5;
            5'h1C: note_code = c_note_f5;
            5'h1D: note_code = c_note_d5;
            5'h1E: note_code = c_note_b4;
            5'h1F: note_code = 4'd13;
            default: note_code = c_note_rest;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/music_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : music_sequencer
// Brief    : Steps through the score one note per beat and emits the tone
//            divider, with play/pause/resume/stop, song select and looping.
// Revision : 1.0 - initial release
// ============================================================================
module music_sequencer
    import music_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SONG_LEN = c_song_len_default,
    parameter int IDX_W    = 6,
    parameter int DIV_W    = 22,
    parameter int SEL_W    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             beat_clk,
    input  logic             play,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [SEL_W-1:0] song_sel,
    output logic [DIV_W-1:0] note_div,
    output logic [IDX_W-1:0] note_idx,
    output logic             playing,
    output logic             done
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(SONG_LEN - 1);

    logic             r_beat_q1;
    logic             r_beat_q2;
    logic             r_beat_q3;
    logic             w_beat_tick;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_next;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] w_sel_next;
    logic [3:0]       w_note_code;
    logic [DIV_W-1:0] w_div_next;
    logic [DIV_W-1:0] r_note_div;
    logic             r_playing;
    logic             r_done;
    logic [DIV_W-1:0] w_lut [16];

    // Divider table folded to constants at elaboration.
    for (genvar gi = 0; gi < 16; gi++) begin : g_lut
        localparam logic [63:0] c_div = note_to_div(4'(gi), 64'(CLK_FREQ));
        assign w_lut[gi] = c_div[DIV_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_q1 <= 1'b0;
            r_beat_q2 <= 1'b0;
            r_beat_q3 <= 1'b0;
        end else begin
            r_beat_q1 <= beat_clk;
            r_beat_q2 <= r_beat_q1;
            r_beat_q3 <= r_beat_q2;
        end
    end

    assign w_beat_tick = r_beat_q2 & ~r_beat_q3;

    // Priority stop > play > beat; lower-priority events in the same cycle are dropped.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_sel_next   = r_sel;
        case (r_state)
            ST_IDLE: begin
                if (play) begin
                    w_state_next = ST_PLAY;
                    w_sel_next   = song_sel;
                    w_idx_next   = '0;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else if (play) begin
                    w_state_next = ST_PAUSE;
                end else if (w_beat_tick) begin
                    if (r_idx == c_last_idx) begin
                        if (loop_en) begin
                            w_idx_next = '0;
                        end else begin
                            w_state_next = ST_DONE;
                        end
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else if (play) begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                    w_idx_next   = '0;
                end else if (play) begin
                    w_state_next = ST_PLAY;
                    w_sel_next   = song_sel;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    // The ROM looks ahead at the next position so the divider lands with the state.
    music_score_rom u_rom (
        .sel       (w_sel_next[0]),
        .idx       (w_idx_next[3:0]),
        .note_code (w_note_code)
    );

    assign w_div_next = (w_state_next == ST_PLAY) ? w_lut[w_note_code] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_sel      <= '0;
            r_note_div <= '0;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_sel      <= w_sel_next;
            r_note_div <= w_div_next;
            r_playing  <= (w_state_next == ST_PLAY);
            r_done     <= (w_state_next == ST_DONE);
        end
    end

    assign note_div = r_note_div;
    assign note_idx = r_idx;
    assign playing  = r_playing;
    assign done     = r_done;

endmodule
`default_nettype wire
